cordic_rotate_seq: RTL and testbench
====================================

Name: cordic_rotate_seq

Overview:
Iterative circular CORDIC in rotation mode. It takes an angle z and drives it to zero, producing cos/sin, which is the reverse direction of our vectoring-mode sqrt/magnitude pipeline. A single shared add/shift datapath is reused for ITERS cycles, with valid/ready handshakes on both sides. It sits beside the sqrt engine in the math-function library and uses the same signed fixed-point format (SYM+INT+DEC bits).

Parameters:
SYM_WIDTH, 1, sign bits of the fixed-point word
INT_WIDTH, 1, integer bits
DEC_WIDTH, 14, fraction bits; W = SYM_WIDTH+INT_WIDTH+DEC_WIDTH (16 by default)
ITERS, 14, number of micro-rotations; legal range 1..DEC_WIDTH

Ports:
clk  input  1  clock; all logic on rising edge
rst_n  input  1  reset, synchronous, active-low
in_valid  input  1  angle offered
in_ready  output  1  block can accept an angle
in_angle  input  W  signed angle in radians, Q(INT).(DEC)
out_valid  output  1  result available
out_ready  input  1  consumer accepts result
out_cos  output  W  signed cos(angle), same format
out_sin  output  W  signed sin(angle), same format
out_err  output  1  input was out of range and was clamped; qualified by out_valid

Behaviour:
- FSM states: IDLE, ITER, DONE. Reset state IDLE.
- Reset (rst_n low at a clock edge) forces: state=IDLE, cnt=0, x=y=z=0, in_ready=1, out_valid=0, out_cos=out_sin=0, out_err=0. Applies mid-ITER or mid-DONE; any in-flight result is discarded.
- in_ready = (state==IDLE), decoded combinationally from state. out_valid = (state==DONE).
- IDLE, on in_valid&in_ready:
  - Clamp the angle to [-PI_HALF, +PI_HALF]; out_err register = 1 if clamping occurred, else 0.
  - Load x=K_GAIN, y=0, z=clamped angle, cnt=0; go to ITER.
- ITER, one micro-rotation per cycle with i=cnt:
  - d=+1 if z>=0 (z sign bit 0), else d=-1.
  - x' = x - d*(y>>>i); y' = y + d*(x>>>i); z' = z - d*ATAN_LUT[i]. All shifts are arithmetic; all sums are W-bit wraparound.
  - cnt increments. When cnt==ITERS-1, the final update is written and the state goes to DONE.
- DONE: out_cos=x, out_sin=y, both held stable. On out_valid&out_ready go to IDLE.
- Latency: acceptance edge, then ITERS edges, then out_valid high. In_valid-accept to out_valid is ITERS+1 cycles (15 by default). Minimum cycles per result is ITERS+2.
- No input is accepted while ITER or DONE; in_angle is ignored outside the accept cycle.
- With out_ready tied high, DONE lasts exactly one cycle. Back-to-back inputs are accepted on the cycle after DONE exits.
- Accuracy: |error| <= ITERS/2+2 LSB against ideal cos/sin for angles within ±PI_HALF.
- Values with K_GAIN prescale never exceed |1.0|, so there is no overflow with INT_WIDTH>=1.

Decomposition:
- Package cordic_pkg holds:
  - FIXED_W derivation.
  - K_GAIN = round(0.607253*2^DEC) = 9949.
  - PI_HALF = 25736.
  - ATAN_LUT[0..13] = 12868, 7596, 4014, 2037, 1023, 512, 256, 128, 64, 32, 16, 8, 4, 2 (atan(2^-i)*2^14).
  - FSM state enum.
- One sub-module is natural: cordic_rot_step. It is the purely combinational single micro-rotation (x,y,z,i,atan_i -> x',y',z'), instantiated once and driven by cnt.
- The FSM, counter and registers live in the top module.

Test Plan:
- Angle 0 (in_valid one cycle, out_ready=1) -> out_valid exactly 15 cycles after accept; cos=16384±9, sin=0±9, err=0.
- Angle 12868 (pi/4) -> cos=11585±9, sin=11585±9.
- Angle -8579 (-pi/6) -> cos=14189±9, sin=-8192±9; then angle 25736 -> cos=0±9, sin=16384±9.
- Angle 30000 (out of range) -> clamped; cos=0±9, sin=16384±9, err=1. Angle -30000 -> sin=-16384±9, err=1.
- Backpressure: out_ready low for 5 cycles in DONE -> out_valid, out_cos, out_sin stable; in_ready=0 throughout; in_valid pulses are ignored. out_ready high -> IDLE next cycle, in_ready=1.
- Reset mid-ITER: rst_n low for 1 cycle at cnt=6 -> next cycle IDLE, in_ready=1, out_valid=0, outputs 0. Next angle 0 -> correct result with no residue from the aborted job.

Source files
------------

// File: rtl/cordic_pkg.sv
// Shared fixed-point format, CORDIC constants and FSM encoding for the
// rotation-mode CORDIC engine.
package cordic_pkg;

    localparam int SYM_WIDTH = 1;
    localparam int INT_WIDTH = 1;
    localparam int DEC_WIDTH = 14;
    localparam int FIXED_W   = SYM_WIDTH + INT_WIDTH + DEC_WIDTH;
    localparam int CNT_W     = 4;

    localparam logic signed [FIXED_W-1:0] K_GAIN      = 16'sd9949;
    localparam logic signed [FIXED_W-1:0] PI_HALF     = 16'sd25736;
    localparam logic signed [FIXED_W-1:0] NEG_PI_HALF = -16'sd25736;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        DONE = 2'd2
    } state_t;

    // atan(2^-i) scaled by 2^DEC_WIDTH
    function automatic logic signed [FIXED_W-1:0] atan_lut(input logic [CNT_W-1:0] i);
        case (i)
            4'd0:    atan_lut = 16'sd12868;
            4'd1:    atan_lut = 16'sd7596;
            4'd2:    atan_lut = 16'sd4014;
            4'd3:    atan_lut = 16'sd2037;
            4'd4:    atan_lut = 16'sd1023;
            4'd5:    atan_lut = 16'sd512;
            4'd6:    atan_lut = 16'sd256;
            4'd7:    atan_lut = 16'sd128;
            4'd8:    atan_lut = 16'sd64;
            4'd9:    atan_lut = 16'sd32;
            4'd10:   atan_lut = 16'sd16;
            4'd11:   atan_lut = 16'sd8;
            4'd12:   atan_lut = 16'sd4;
            4'd13:   atan_lut = 16'sd2;
            default: atan_lut = 16'sd0;
        endcase
    endfunction

endpackage

// File: rtl/cordic_rotate_seq_if.sv
// Angle-in / cos-sin-out handshake bundle of the sequential CORDIC rotator.
interface cordic_rotate_seq_if;

    logic                                  in_valid;
    logic                                  in_ready;
    logic signed [cordic_pkg::FIXED_W-1:0] in_angle;
    logic                                  out_valid;
    logic                                  out_ready;
    logic signed [cordic_pkg::FIXED_W-1:0] out_cos;
    logic signed [cordic_pkg::FIXED_W-1:0] out_sin;
    logic                                  out_err;

    modport master (
        output in_valid, in_angle, out_ready,
        input  in_ready, out_valid, out_cos, out_sin, out_err
    );

    modport slave (
        input  in_valid, in_angle, out_ready,
        output in_ready, out_valid, out_cos, out_sin, out_err
    );

endinterface

// File: rtl/cordic_rot_step.sv
// One combinational circular micro-rotation; direction follows the sign of z
// so that the residual angle is driven toward zero.
module cordic_rot_step
    import cordic_pkg::*;
(
    input  logic signed [FIXED_W-1:0] x,
    input  logic signed [FIXED_W-1:0] y,
    input  logic signed [FIXED_W-1:0] z,
    input  logic        [CNT_W-1:0]   i,
    input  logic signed [FIXED_W-1:0] atan_i,
    output logic signed [FIXED_W-1:0] x_next,
    output logic signed [FIXED_W-1:0] y_next,
    output logic signed [FIXED_W-1:0] z_next
);

    logic                      neg_s;
    logic signed [FIXED_W-1:0] x_sh_s;
    logic signed [FIXED_W-1:0] y_sh_s;

    assign neg_s  = z[FIXED_W-1];
    assign x_sh_s = x >>> i;
    assign y_sh_s = y >>> i;

    assign x_next = neg_s ? (x + y_sh_s) : (x - y_sh_s);
    assign y_next = neg_s ? (y - x_sh_s) : (y + x_sh_s);
    assign z_next = neg_s ? (z + atan_i) : (z - atan_i);

endmodule

// File: rtl/cordic_rotate_seq.sv
// Iterative rotation-mode CORDIC: accepts an angle, runs ITERS micro-rotations
// through one shared step, and holds cos/sin until the consumer takes them.
module cordic_rotate_seq
    import cordic_pkg::*;
#(
    parameter int ITERS = 14
) (
    input  logic               clk,
    input  logic               rst_n,
    cordic_rotate_seq_if.slave bus
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ITERS - 1);

    state_t                    state_r;
    logic        [CNT_W-1:0]   cnt_r;
    logic signed [FIXED_W-1:0] x_r;
    logic signed [FIXED_W-1:0] y_r;
    logic signed [FIXED_W-1:0] z_r;
    logic signed [FIXED_W-1:0] cos_r;
    logic signed [FIXED_W-1:0] sin_r;
    logic                      err_r;

    logic signed [FIXED_W-1:0] clamp_s;
    logic                      clamp_err_s;
    logic signed [FIXED_W-1:0] x_next_s;
    logic signed [FIXED_W-1:0] y_next_s;
    logic signed [FIXED_W-1:0] z_next_s;

    // Limit the incoming angle to the convergence range of circular CORDIC.
    always_comb begin
        clamp_s     = bus.in_angle;
        clamp_err_s = 1'b0;
        if (bus.in_angle > PI_HALF) begin
            clamp_s     = PI_HALF;
            clamp_err_s = 1'b1;
        end else if (bus.in_angle < NEG_PI_HALF) begin
            clamp_s     = NEG_PI_HALF;
            clamp_err_s = 1'b1;
        end else begin
            clamp_s     = bus.in_angle;
            clamp_err_s = 1'b0;
        end
    end

    cordic_rot_step u_step (
        .x      (x_r),
        .y      (y_r),
        .z      (z_r),
        .i      (cnt_r),
        .atan_i (atan_lut(cnt_r)),
        .x_next (x_next_s),
        .y_next (y_next_s),
        .z_next (z_next_s)
    );

    // Control FSM, iteration counter and datapath/result registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= IDLE;
            cnt_r   <= {CNT_W{1'b0}};
            x_r     <= 16'sd0;
            y_r     <= 16'sd0;
            z_r     <= 16'sd0;
            cos_r   <= 16'sd0;
            sin_r   <= 16'sd0;
            err_r   <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (bus.in_valid) begin
                        x_r     <= K_GAIN;
                        y_r     <= 16'sd0;
                        z_r     <= clamp_s;
                        err_r   <= clamp_err_s;
                        cnt_r   <= {CNT_W{1'b0}};
                        state_r <= ITER;
                    end
                end
                ITER: begin
                    x_r   <= x_next_s;
                    y_r   <= y_next_s;
                    z_r   <= z_next_s;
                    cnt_r <= cnt_r + 4'd1;
                    // Results are captured from the final step so DONE presents them immediately.
                    if (cnt_r == LAST_CNT) begin
                        cos_r   <= x_next_s;
                        sin_r   <= y_next_s;
                        state_r <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state_r <= IDLE;
                    end
                end
                default: state_r <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (state_r == IDLE);
    assign bus.out_valid = (state_r == DONE);
    assign bus.out_cos   = cos_r;
    assign bus.out_sin   = sin_r;
    assign bus.out_err   = err_r;

endmodule

// File: tb/tb_cordic_rotate_seq.sv
// Self-checking bench for cordic_rotate_seq: directed table, random angles
// against a trigonometric reference, backpressure and mid-iteration reset.
module tb_cordic_rotate_seq;

    localparam int    TOL   = 9;
    localparam int    LAT   = 15;
    localparam real   SCALE = 16384.0;
    localparam real   HPI   = 1.5707963267948966;

    typedef struct {
        int angle;
        int exp_cos;
        int exp_sin;
        int exp_err;
    } vec_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;
    vec_t vecs[6];

    always #5 clk = ~clk;

    cordic_rotate_seq_if bif ();

    cordic_rotate_seq #(.ITERS(14)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bif)
    );

    task automatic chk(input string name, input int act, input int exp, input int tol);
        n_cmp++;
        if (act > exp + tol || act < exp - tol) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d (tol %0d)", name, act, exp, tol);
        end
    endtask

    // Ideal cos/sin of the angle after limiting it to +/- pi/2.
    function automatic real clamp_rad(input int angle);
        real r;
        r = angle / SCALE;
        if (r > HPI) r = HPI;
        if (r < -HPI) r = -HPI;
        return r;
    endfunction

    function automatic int model_cos(input int angle);
        return int'($cos(clamp_rad(angle)) * SCALE);
    endfunction

    function automatic int model_sin(input int angle);
        return int'($sin(clamp_rad(angle)) * SCALE);
    endfunction

    // Offer one angle, then wait (bounded) for out_valid. Latency counts edges
    // starting with the accept edge. Returns sampled right after out_valid rises.
    task automatic run_job(input int angle, input string tag,
                           output int cos_v, output int sin_v, output int err_v);
        int lat;
        @(negedge clk);
        chk({tag, " in_ready"}, int'(bif.in_ready), 1, 0);
        bif.in_valid = 1'b1;
        bif.in_angle = 16'(angle);
        @(posedge clk);
        #1;
        bif.in_valid = 1'b0;
        lat = 1;
        while (!bif.out_valid && lat < 60) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk({tag, " latency"}, lat, LAT, 0);
        cos_v = int'(bif.out_cos);
        sin_v = int'(bif.out_sin);
        err_v = int'(bif.out_err);
    endtask

    task automatic check_release(input string tag);
        @(posedge clk);
        #1;
        chk({tag, " idle in_ready"}, int'(bif.in_ready), 1, 0);
        chk({tag, " idle out_valid"}, int'(bif.out_valid), 0, 0);
    endtask

    initial begin
        int c, s, e, a, snap_c, snap_s;

        vecs[0] = '{0,      16384,  0,      0};
        vecs[1] = '{12868,  11585,  11585,  0};
        vecs[2] = '{-8579,  14189,  -8192,  0};
        vecs[3] = '{25736,  0,      16384,  0};
        vecs[4] = '{30000,  0,      16384,  1};
        vecs[5] = '{-30000, 0,      -16384, 1};

        bif.in_valid  = 1'b0;
        bif.in_angle  = '0;
        bif.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset in_ready", int'(bif.in_ready), 1, 0);
        chk("reset out_valid", int'(bif.out_valid), 0, 0);
        chk("reset cos", int'(bif.out_cos), 0, 0);
        chk("reset sin", int'(bif.out_sin), 0, 0);
        chk("reset err", int'(bif.out_err), 0, 0);
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++) begin
            run_job(vecs[i].angle, $sformatf("vec%0d", i), c, s, e);
            chk($sformatf("vec%0d cos", i), c, vecs[i].exp_cos, TOL);
            chk($sformatf("vec%0d sin", i), s, vecs[i].exp_sin, TOL);
            chk($sformatf("vec%0d err", i), e, vecs[i].exp_err, 0);
            check_release($sformatf("vec%0d", i));
        end

        for (int i = 0; i < 20; i++) begin
            a = int'($urandom_range(0, 65535)) - 32768;
            run_job(a, $sformatf("rnd%0d", i), c, s, e);
            chk($sformatf("rnd%0d cos a=%0d", i, a), c, model_cos(a), TOL);
            chk($sformatf("rnd%0d sin a=%0d", i, a), s, model_sin(a), TOL);
            chk($sformatf("rnd%0d err a=%0d", i, a), e,
                (a > 25736 || a < -25736) ? 1 : 0, 0);
            check_release($sformatf("rnd%0d", i));
        end

        // Backpressure: result held for 5 cycles while stray inputs are offered.
        bif.out_ready = 1'b0;
        run_job(-8579, "bp", c, s, e);
        chk("bp cos", c, 14189, TOL);
        chk("bp sin", s, -8192, TOL);
        snap_c = c;
        snap_s = s;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            bif.in_valid = 1'b1;
            bif.in_angle = 16'($urandom);
            @(posedge clk);
            #1;
            bif.in_valid = 1'b0;
            chk("bp out_valid", int'(bif.out_valid), 1, 0);
            chk("bp in_ready", int'(bif.in_ready), 0, 0);
            chk("bp cos hold", int'(bif.out_cos), snap_c, 0);
            chk("bp sin hold", int'(bif.out_sin), snap_s, 0);
        end
        bif.out_ready = 1'b1;
        check_release("bp");
        run_job(12868, "post_bp", c, s, e);
        chk("post_bp cos", c, 11585, TOL);
        chk("post_bp sin", s, 11585, TOL);
        check_release("post_bp");

        // Reset asserted for one edge while cnt==6 of a clamped job.
        @(negedge clk);
        bif.in_valid = 1'b1;
        bif.in_angle = 16'(30000);
        @(posedge clk);
        #1;
        bif.in_valid = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("mid_rst in_ready", int'(bif.in_ready), 1, 0);
        chk("mid_rst out_valid", int'(bif.out_valid), 0, 0);
        chk("mid_rst cos", int'(bif.out_cos), 0, 0);
        chk("mid_rst sin", int'(bif.out_sin), 0, 0);
        chk("mid_rst err", int'(bif.out_err), 0, 0);
        run_job(0, "after_rst", c, s, e);
        chk("after_rst cos", c, 16384, TOL);
        chk("after_rst sin", s, 0, TOL);
        chk("after_rst err", e, 0, 0);
        check_release("after_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
